// File: rtl/bcd_count_display_pkg.sv
// Shared constants for the BCD tick counter and its 7-segment scanner.
package bcd_count_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_RESET  = 4'b1110;

    // Active-low segment patterns, bit order g,f,e,d,c,b,a.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

endpackage

// File: rtl/bcd_count_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes blank the digit.
module seg7_decode
    import bcd_count_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup with explicit indices; 10..15 fall through to blank.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_TABLE[0];
            4'd1:    seg = SEG_TABLE[1];
            4'd2:    seg = SEG_TABLE[2];
            4'd3:    seg = SEG_TABLE[3];
            4'd4:    seg = SEG_TABLE[4];
            4'd5:    seg = SEG_TABLE[5];
            4'd6:    seg = SEG_TABLE[6];
            4'd7:    seg = SEG_TABLE[7];
            4'd8:    seg = SEG_TABLE[8];
            4'd9:    seg = SEG_TABLE[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_count_display.sv
// Counts rising edges of an asynchronous tick source in a 4-digit BCD
// up/down counter and scans the count onto a common-anode 7-seg display.
module bcd_count_display
    import bcd_count_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_src,
    input  logic        cnt_en,
    input  logic        up_dn,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        carry,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              s1_reg, s2_reg, s3_reg;
    logic [1:0]        vld_reg;
    logic              armed_reg;
    logic              tick;
    logic [15:0]       count_reg;
    logic              carry_reg;
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [1:0]        digit_idx_reg;
    logic [3:0]        an_reg;
    logic [6:0]        seg_reg;
    logic [6:0]        seg_dec;

    bcd_digit_t        dig [4];
    logic [3:0]        is9, is0, inc_en, dec_en;
    logic [15:0]       inc_cnt, dec_cnt;
    logic              wrap_up, wrap_dn;

    // Two-flop synchroniser plus edge-detect delay. vld_reg marks when s2
    // holds a genuinely sampled level rather than its reset value, so that
    // arming only happens after a real low has been observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            s3_reg    <= 1'b0;
            vld_reg   <= 2'b00;
            armed_reg <= 1'b0;
        end else begin
            s1_reg    <= tick_src;
            s2_reg    <= s1_reg;
            s3_reg    <= s2_reg;
            vld_reg   <= {vld_reg[0], 1'b1};
            armed_reg <= armed_reg | (vld_reg[1] & ~s2_reg);
        end
    end

    assign tick = s2_reg & ~s3_reg & armed_reg;

    // Per-digit BCD increment/decrement with ripple from the lower digits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign dig[gi] = count_reg[gi*4 +: 4];
        assign is9[gi] = (dig[gi] == BCD_MAX);
        assign is0[gi] = (dig[gi] == 4'd0);

        if (gi == 0) begin : g_lsd
            assign inc_en[gi] = 1'b1;
            assign dec_en[gi] = 1'b1;
        end else begin : g_upper
            assign inc_en[gi] = &is9[gi-1:0];
            assign dec_en[gi] = &is0[gi-1:0];
        end

        assign inc_cnt[gi*4 +: 4] = !inc_en[gi] ? dig[gi] :
                                    is9[gi]     ? 4'd0    : dig[gi] + 4'd1;
        assign dec_cnt[gi*4 +: 4] = !dec_en[gi] ? dig[gi] :
                                    is0[gi]     ? BCD_MAX : dig[gi] - 4'd1;
    end

    assign wrap_up = &is9;
    assign wrap_dn = &is0;

    // Count register: clear beats tick; carry pulses only on a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 16'h0000;
            carry_reg <= 1'b0;
        end else if (clr) begin
            count_reg <= 16'h0000;
            carry_reg <= 1'b0;
        end else if (tick && cnt_en) begin
            if (up_dn) begin
                count_reg <= inc_cnt;
                carry_reg <= wrap_up;
            end else begin
                count_reg <= dec_cnt;
                carry_reg <= wrap_dn;
            end
        end else begin
            carry_reg <= 1'b0;
        end
    end

    // Scan timer: each digit slot lasts SCAN_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= digit_idx_reg + 2'd1;
        end else begin
            scan_cnt_reg  <= scan_cnt_reg + SCAN_W'(1);
        end
    end

    seg7_decode u_seg7_decode (
        .bcd (dig[digit_idx_reg]),
        .seg (seg_dec)
    );

    // Display outputs follow the index one clock later and show the live count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg  <= AN_RESET;
            seg_reg <= SEG_TABLE[0];
        end else begin
            an_reg  <= ~(4'b0001 << digit_idx_reg);
            seg_reg <= seg_dec;
        end
    end

    assign count_bcd = count_reg;
    assign carry     = carry_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;

endmodule

// File: tb/tb_bcd_count_display.sv
// Randomised self-checking bench for bcd_count_display (SCAN_DIV = 4).
module tb_bcd_count_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_src = 1'b1;
    logic        cnt_en = 1'b1;
    logic        up_dn = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] count_bcd;
    logic        carry;
    logic [3:0]  an;
    logic [6:0]  seg;

    int vectors = 0;
    int errors  = 0;
    int model   = 0;     // reference count as a plain integer 0..9999
    int cyc     = 0;     // clocks since reset release

    bcd_count_display #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_src  (tick_src),
        .cnt_en    (cnt_en),
        .up_dn     (up_dn),
        .clr       (clr),
        .count_bcd (count_bcd),
        .carry     (carry),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic int digit_of(input int v, input int idx);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        return (v / p) % 10;
    endfunction

    // One full tick_src pulse; checks latency, new count and carry pulse.
    task automatic tick(input string name);
        logic [15:0] prev;
        logic        exp_c;
        prev = bcd16(model);
        @(negedge clk) tick_src = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (count_bcd !== prev) begin
            errors++;
            $display("FAIL %s early: count %h expected %h", name, count_bcd, prev);
        end
        @(posedge clk);
        #1;
        exp_c = 1'b0;
        if (cnt_en) begin
            if (up_dn) begin
                exp_c = (model == 9999);
                model = (model + 1) % 10000;
            end else begin
                exp_c = (model == 0);
                model = (model + 9999) % 10000;
            end
        end
        vectors++;
        if (count_bcd !== bcd16(model) || carry !== exp_c) begin
            errors++;
            $display("FAIL %s: count %h carry %b expected %h carry %b",
                     name, count_bcd, carry, bcd16(model), exp_c);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (carry !== 1'b0 || count_bcd !== bcd16(model)) begin
            errors++;
            $display("FAIL %s after: count %h carry %b expected %h carry 0",
                     name, count_bcd, carry, bcd16(model));
        end
        @(negedge clk) tick_src = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1;
        model = 0;
        vectors++;
        if (count_bcd !== 16'h0000 || carry !== 1'b0) begin
            errors++;
            $display("FAIL clear: count %h carry %b expected 0000 carry 0", count_bcd, carry);
        end
        @(negedge clk) clr = 1'b0;
    endtask

    // Tick whose counting edge coincides with clr; clear must win.
    task automatic clr_with_tick(input string name);
        @(negedge clk) tick_src = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1;
        model = 0;
        vectors++;
        if (count_bcd !== 16'h0000 || carry !== 1'b0) begin
            errors++;
            $display("FAIL %s: count %h carry %b expected 0000 carry 0", name, count_bcd, carry);
        end
        @(negedge clk);
        clr = 1'b0;
        tick_src = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_scan(input int n);
        int         idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        repeat (n) begin
            @(posedge clk);
            #1;
            idx     = (cyc == 0) ? 0 : ((cyc - 1) / SD) % 4;
            exp_an  = ~(4'b0001 << idx);
            exp_seg = seg_of(digit_of(model, idx));
            vectors++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL scan cyc %0d: an %b seg %b expected an %b seg %b",
                         cyc, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_reset();
        tick_src = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (count_bcd !== 16'h0000 || carry !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_state: count %h carry %b an %b seg %b expected 0000 0 1110 1000000",
                     count_bcd, carry, an, seg);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (count_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL high_at_release: count %h expected 0000", count_bcd);
        end
        @(negedge clk) tick_src = 1'b0;
        repeat (4) @(negedge clk);
        tick("first_tick");
    endtask

    task automatic test_up_wrap();
        up_dn  = 1'b1;
        cnt_en = 1'b1;
        repeat (998) tick("preload_up");
        tick("up_0999");
        do_clear();
        up_dn = 1'b0;
        tick("down_to_9999");
        up_dn = 1'b1;
        tick("up_wrap");
    endtask

    task automatic test_down_wrap();
        up_dn = 1'b0;
        tick("down_wrap");
        tick("down_9998");
    endtask

    task automatic test_cnt_en();
        cnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up_dn = 1'($urandom_range(1));
            tick("cnt_en_off");
        end
        cnt_en = 1'b1;
    endtask

    task automatic test_clr();
        do_clear();
        up_dn = 1'b1;
        repeat (42) tick("preload_42");
        clr_with_tick("clr_at_0042");
        up_dn = 1'b0;
        tick("down_to_9999b");
        up_dn = 1'b1;
        clr_with_tick("clr_at_wrap");
    endtask

    task automatic test_scan();
        do_clear();
        up_dn = 1'b1;
        repeat (1234) tick("preload_1234");
        check_scan(16);
    endtask

    task automatic test_mid_reset();
        up_dn = 1'b0;
        repeat (667) tick("preload_0567");
        vectors++;
        if (count_bcd !== 16'h0567) begin
            errors++;
            $display("FAIL preload_0567: count %h expected 0567", count_bcd);
        end
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model = 0;
        vectors++;
        if (count_bcd !== 16'h0000 || carry !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL async_reset: count %h carry %b an %b seg %b expected 0000 0 1110 1000000",
                     count_bcd, carry, an, seg);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        up_dn = 1'b1;
        tick("post_reset_tick");
        check_scan(12);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            cnt_en = ($urandom_range(3) != 0);
            up_dn  = 1'($urandom_range(1));
            if ($urandom_range(40) == 0) do_clear();
            tick("random");
        end
        cnt_en = 1'b1;
        check_scan(20);
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_cnt_en();
        test_clr();
        test_scan();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
